// File: rtl/rv32i_boot_loader_if.sv
// Byte-stream receive handshake plus ITCM write port of the boot loader.
// The loader binds to 'slave'; the byte source / ITCM side uses 'master'.
interface rv32i_boot_loader_if #(
  parameter int ADDR_WTH = 32,
  parameter int WORD_WTH = 32
);
  logic                rx_valid_i;
  logic [7:0]          rx_data_i;
  logic                rx_ready_o;
  logic                ld_itcm_we_o;
  logic [ADDR_WTH-1:0] ld_itcm_addr_o;
  logic [WORD_WTH-1:0] ld_itcm_wdata_o;

  modport slave (
    input  rx_valid_i, rx_data_i,
    output rx_ready_o, ld_itcm_we_o, ld_itcm_addr_o, ld_itcm_wdata_o
  );

  modport master (
    output rx_valid_i, rx_data_i,
    input  rx_ready_o, ld_itcm_we_o, ld_itcm_addr_o, ld_itcm_wdata_o
  );
endinterface

// File: rtl/rv32i_boot_loader.sv
// Frame-based program loader: receives addr/len/payload/checksum bytes, writes
// payload words into the ITCM and releases the RV32I core once the sum matches.
module rv32i_boot_loader #(
  parameter int                  WORD_WTH    = 32,
  parameter int                  ADDR_WTH    = 32,
  parameter logic [ADDR_WTH-1:0] ITCM_BASE   = '0,
  parameter int                  ITCM_WORDS  = 4096,
  parameter int                  TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  rv32i_boot_loader_if.slave  bus,
  output logic                core_rst_o,
  output logic [ADDR_WTH-1:0] init_pc_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          err_o
);
  typedef enum logic [2:0] {
    HDR_ADDR, HDR_LEN, CHECK_HDR, PAYLOAD, CSUM, VERIFY, DONE, ERROR
  } state_t;

  localparam int EW   = ADDR_WTH + 3;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [EW-1:0]   ITCM_BYTES = EW'(ITCM_WORDS) << 2;

  state_t              state, state_nx;
  logic [1:0]          byte_cnt;
  logic [31:0]         asm_q;
  logic [31:0]         field;
  logic [ADDR_WTH-1:0] addr_r;
  logic [31:0]         len_r, word_cnt, sum_q;
  logic [TO_W-1:0]     to_cnt;
  logic                rdy_q, we_q;
  logic [ADDR_WTH-1:0] wr_addr_q;
  logic [WORD_WTH-1:0] wr_data_q;
  logic                receiving, rdy_nx, xfer, last, to_arm, timeout;
  logic [EW-1:0]       off, span_end;
  logic                hdr_bad, sum_ok;

  assign xfer  = bus.rx_valid_i && rdy_q;
  assign last  = xfer && (byte_cnt == 2'd3);
  assign field = {bus.rx_data_i, asm_q[23:0]};

  assign receiving = (state == HDR_ADDR) || (state == HDR_LEN) ||
                     (state == PAYLOAD)  || (state == CSUM);
  // Waiting for the first byte of a frame is never a timeout.
  assign to_arm  = receiving && !((state == HDR_ADDR) && (byte_cnt == 2'd0));
  assign timeout = to_arm && !xfer && (to_cnt == TO_LAST);

  // Offset from the ITCM base in widened arithmetic: a borrow marks A < base,
  // and the end address cannot wrap.
  assign off      = EW'(addr_r) - EW'(ITCM_BASE);
  assign span_end = off + EW'({len_r, 2'b00});
  assign hdr_bad  = (addr_r[1:0] != 2'b00) || off[EW-1] || (span_end > ITCM_BYTES);
  assign sum_ok   = (asm_q == sum_q);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR_ADDR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR_ADDR:  if (last) state_nx = HDR_LEN;
      HDR_LEN:   if (last) state_nx = CHECK_HDR;
      CHECK_HDR: begin
        if (hdr_bad)           state_nx = ERROR;
        else if (len_r == '0)  state_nx = CSUM;
        else                   state_nx = PAYLOAD;
      end
      PAYLOAD:   if (last && (word_cnt == len_r - 32'd1)) state_nx = CSUM;
      CSUM:      if (last) state_nx = VERIFY;
      VERIFY:    state_nx = sum_ok ? DONE : ERROR;
      default:   state_nx = state;
    endcase
    if (timeout) state_nx = HDR_ADDR;
    rdy_nx = (state_nx == HDR_ADDR) || (state_nx == HDR_LEN) ||
             (state_nx == PAYLOAD)  || (state_nx == CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      addr_r     <= '0;
      len_r      <= '0;
      word_cnt   <= '0;
      sum_q      <= '0;
      to_cnt     <= '0;
      core_rst_o <= 1'b1;
      init_pc_o  <= ITCM_BASE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 2'b00;
    end else begin
      rdy_q <= rdy_nx;
      we_q  <= 1'b0;
      if (!to_arm || xfer) to_cnt <= '0;
      else                 to_cnt <= to_cnt + 1'b1;

      if (xfer) begin
        asm_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data_i;
        byte_cnt <= byte_cnt + 2'd1;
        if (err_o == 2'b11)     err_o  <= 2'b00;
        if (state == HDR_ADDR) busy_o <= 1'b1;
      end

      if (last) begin
        case (state)
          HDR_ADDR: addr_r <= ADDR_WTH'(field);
          HDR_LEN:  len_r  <= field;
          PAYLOAD: begin
            we_q      <= 1'b1;
            wr_addr_q <= addr_r + ADDR_WTH'({word_cnt, 2'b00});
            wr_data_q <= WORD_WTH'(field);
            sum_q     <= sum_q + field;
            word_cnt  <= word_cnt + 32'd1;
          end
          default: ;
        endcase
      end

      if ((state == CHECK_HDR) && hdr_bad) begin
        err_o  <= 2'b10;
        busy_o <= 1'b0;
      end

      if (state == VERIFY) begin
        busy_o <= 1'b0;
        if (sum_ok) begin
          core_rst_o <= 1'b0;
          done_o     <= 1'b1;
          init_pc_o  <= addr_r;
        end else begin
          err_o <= 2'b01;
        end
      end

      // Abandon the frame; words already written stay in the ITCM.
      if (timeout) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        sum_q    <= '0;
        to_cnt   <= '0;
        err_o    <= 2'b11;
        busy_o   <= 1'b0;
      end
    end
  end

  assign bus.rx_ready_o      = rdy_q;
  assign bus.ld_itcm_we_o    = we_q;
  assign bus.ld_itcm_addr_o  = wr_addr_q;
  assign bus.ld_itcm_wdata_o = wr_data_q;
endmodule

// File: tb/tb_rv32i_boot_loader.sv
// Directed and randomized frames against a frame-level reference model of the
// loader (range rule, checksum rule, expected ITCM write list).
module tb_rv32i_boot_loader;
  localparam int          TO    = 16;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rst, busy, done;
  logic [31:0] init_pc;
  logic [1:0]  err;

  always #5 clk = ~clk;

  rv32i_boot_loader_if #(.ADDR_WTH(32), .WORD_WTH(32)) bus();

  rv32i_boot_loader #(
    .WORD_WTH(32), .ADDR_WTH(32), .ITCM_BASE(BASE),
    .ITCM_WORDS(WORDS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_rst_o(core_rst), .init_pc_o(init_pc),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] pay[$];
  logic [63:0] wq[$];

  always @(negedge clk)
    if (bus.ld_itcm_we_o) wq.push_back({bus.ld_itcm_addr_o, bus.ld_itcm_wdata_o});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    step(2);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tog);
    int n = 0;
    bit ok = 1'b0;
    if (tog) begin
      bus.rx_valid_i = 1'b0;
      step(1);
    end
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    while (!ok) begin
      @(negedge clk);
      ok = bus.rx_ready_o;
      step(1);
      n++;
      if (!ok && n > 40) begin
        chk("rx_ready_wait", {63'd0, bus.rx_ready_o}, 64'd1);
        break;
      end
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit tog);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], tog);
  endtask

  function automatic logic [31:0] qsum();
    logic [31:0] s = 32'd0;
    foreach (pay[i]) s += pay[i];
    return s;
  endfunction

  // Frame outcome from the frame rules alone: 2 = range/alignment, 1 = checksum, 0 = ok.
  function automatic logic [1:0] ref_err(input logic [31:0] a, input logic [31:0] n,
                                         input logic [31:0] c);
    longint unsigned la = a;
    longint unsigned ln = n;
    longint unsigned lb = BASE;
    if ((la % 4) != 0 || la < lb || la + 4 * ln > lb + 4 * WORDS) return 2'd2;
    if (c != qsum()) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk_writes(input string tag, input logic [31:0] a);
    chk({tag, ".nwr"}, wq.size(), pay.size());
    for (int i = 0; i < wq.size() && i < pay.size(); i++) begin
      chk({tag, ".waddr"}, wq[i][63:32], a + 32'(4 * i));
      chk({tag, ".wdata"}, wq[i][31:0], pay[i]);
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] a, input logic [31:0] n,
                           input logic [31:0] c, input bit tog);
    logic [1:0] e;
    e = ref_err(a, n, c);
    do_reset();
    send_word(a, tog);
    send_word(n, tog);
    if (e == 2'd2) begin
      step(2);
      chk({tag, ".err"}, err, 2'd2);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".rdy"}, bus.rx_ready_o, 0);
      chk({tag, ".core_rst"}, core_rst, 1);
      chk({tag, ".nwr"}, wq.size(), 0);
      return;
    end
    foreach (pay[i]) send_word(pay[i], tog);
    send_word(c, tog);
    chk({tag, ".core_rst_verify"}, core_rst, 1);
    step(1);
    chk({tag, ".core_rst"}, core_rst, (e == 2'd0) ? 1'b0 : 1'b1);
    chk({tag, ".done"}, done, (e == 2'd0) ? 1'b1 : 1'b0);
    chk({tag, ".err"}, err, e);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".init_pc"}, init_pc, (e == 2'd0) ? a : BASE);
    step(4);
    chk({tag, ".rdy_hold"}, bus.rx_ready_o, 0);
    chk({tag, ".err_hold"}, err, e);
    chk_writes(tag, a);
  endtask

  initial begin
    logic [31:0] a, n, c;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    rst = 1'b1;
    step(2);
    chk("rst.core_rst", core_rst, 1);
    chk("rst.rdy", bus.rx_ready_o, 0);
    chk("rst.we", bus.ld_itcm_we_o, 0);
    chk("rst.addr", bus.ld_itcm_addr_o, 0);
    chk("rst.wdata", bus.ld_itcm_wdata_o, 0);
    chk("rst.init_pc", init_pc, BASE);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);

    pay = '{32'h0000_0013, 32'h00A0_0093};
    run_frame("good", 32'h100, 32'd2, 32'h00A0_00A6, 1'b0);
    run_frame("badsum", 32'h100, 32'd2, 32'h0, 1'b0);

    pay.delete();
    run_frame("misalign", 32'h102, 32'd1, 32'h0, 1'b0);
    run_frame("overrun", 32'h3FFC, 32'd2, 32'h0, 1'b0);
    run_frame("nowrap", 32'hFFFF_FFFC, 32'd1, 32'h0, 1'b0);
    run_frame("n0", 32'h200, 32'd0, 32'h0, 1'b0);

    pay = '{$urandom(), $urandom()};
    run_frame("top_edge", 32'h3FF8, 32'd2, qsum(), 1'b1);

    for (int r = 0; r < 4; r++) begin
      pay.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < int'(n); i++) pay.push_back($urandom());
      a = 32'($urandom_range(0, 4080)) << 2;
      c = qsum();
      if ($urandom_range(0, 3) == 0) c = c ^ 32'h1;
      run_frame($sformatf("rand%0d", r), a, n, c, 1'($urandom_range(0, 1)));
    end

    // Stall inside the length field, then recover with a full frame.
    do_reset();
    pay = '{$urandom(), $urandom(), $urandom()};
    a = 32'h0000_0800;
    n = 32'd3;
    send_word(a, 1'b0);
    send_byte(n[7:0], 1'b0);
    chk("to.busy", busy, 1);
    step(10);
    chk("to.early_err", err, 0);
    step(10);
    chk("to.err", err, 2'd3);
    chk("to.busy_clr", busy, 0);
    chk("to.rdy", bus.rx_ready_o, 1);
    chk("to.core_rst", core_rst, 1);
    send_byte(a[7:0], 1'b0);
    chk("to.err_clr", err, 0);
    for (int k = 1; k < 4; k++) send_byte(a[8*k +: 8], 1'b0);
    send_word(n, 1'b0);
    foreach (pay[i]) send_word(pay[i], 1'b0);
    send_word(qsum(), 1'b0);
    step(1);
    chk("to.done", done, 1);
    chk("to.core_rst_rel", core_rst, 0);
    chk("to.init_pc", init_pc, a);
    chk_writes("to", a);

    // Reset in the middle of the payload, then a fresh frame with valid toggling.
    do_reset();
    pay = '{$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    a = 32'h0000_1000;
    send_word(a, 1'b0);
    send_word(32'd5, 1'b0);
    for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0);
    step(1);
    chk("mid.nwr", wq.size(), 3);
    rst = 1'b1;
    step(1);
    chk("mid.core_rst", core_rst, 1);
    chk("mid.busy", busy, 0);
    chk("mid.rdy", bus.rx_ready_o, 0);
    chk("mid.we", bus.ld_itcm_we_o, 0);
    chk("mid.addr", bus.ld_itcm_addr_o, 0);
    pay = '{$urandom(), $urandom(), $urandom(), $urandom()};
    run_frame("after_rst", 32'h0000_2040, 32'd4, qsum(), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
